// File: rtl/decompress_d.sv
// decompress_d: unpacks LSB-first D-bit coefficients from a byte stream and emits decompressed pairs
module decompress_d #(
    parameter int D = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set,
    input  logic        readin,
    input  logic        full_in,
    input  logic [7:0]  decomp_din,
    input  logic [8:0]  in_index,
    input  logic        readout,
    output logic [15:0] decomp_dout_1,
    output logic [15:0] decomp_dout_2,
    output logic [6:0]  out_index,
    output logic        readin_ok,
    output logic        readout_ok,
    output logic        done,
    output logic        err
);
    localparam int Q = 3329;
    localparam int N = 256;
    localparam int ACC_W = 2 * D + 8;
    localparam int CW = $clog2(ACC_W + 1);
    localparam int PW = D + 12;
    localparam logic [CW-1:0] PAIR_BITS = CW'(2 * D);
    localparam logic [8:0] LAST_BYTE = 9'(32 * D - 1);
    localparam logic [6:0] LAST_PAIR = 7'(N / 2 - 1);
    localparam logic [PW-1:0] QW = PW'(Q);
    localparam logic [PW-1:0] HALF = PW'(1) << (D - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state, state_n;
    logic [ACC_W-1:0] acc, acc_sh, acc_n;
    logic [CW-1:0] acc_cnt, cnt_sh, cnt_n;
    logic [8:0] byte_cnt;
    logic [6:0] pair_cnt;
    logic accept, take, ext, err_n;

    assign readin_ok = (state == RUN) && (acc_cnt <= PAIR_BITS);
    assign accept = readin && readin_ok;
    assign take = readout && readout_ok;
    assign ext = (state == RUN || state == FLUSH) && (acc_cnt >= PAIR_BITS) && (!readout_ok || readout);
    assign done = (state == DONE);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end

    // next state: set low aborts from anywhere, full_in ends input, last pair consumed ends output
    always_comb begin
        state_n = !set ? IDLE :
                  (state == IDLE) ? RUN :
                  (state == RUN && accept && full_in) ? FLUSH :
                  (state == FLUSH && take && out_index == LAST_PAIR) ? DONE : state;
    end

    // accumulator update: drop an extracted pair first, then append the new byte above what remains
    always_comb begin
        acc_sh = ext ? acc >> (2 * D) : acc;
        cnt_sh = ext ? acc_cnt - PAIR_BITS : acc_cnt;
        acc_n = accept ? acc_sh | (ACC_W'(decomp_din) << cnt_sh) : acc_sh;
        cnt_n = accept ? cnt_sh + CW'(8) : cnt_sh;
        err_n = err
              | (accept && (in_index != byte_cnt || (full_in && byte_cnt != LAST_BYTE)))
              | (readin && (state == FLUSH || state == DONE));
    end

    // datapath registers: accumulator, counters, output pair and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            acc_cnt <= '0;
            byte_cnt <= '0;
            pair_cnt <= '0;
            decomp_dout_1 <= '0;
            decomp_dout_2 <= '0;
            out_index <= '0;
            readout_ok <= 1'b0;
            err <= 1'b0;
        end else if (!set) begin
            acc <= '0;
            acc_cnt <= '0;
            byte_cnt <= '0;
            pair_cnt <= '0;
            decomp_dout_1 <= '0;
            decomp_dout_2 <= '0;
            out_index <= '0;
            readout_ok <= 1'b0;
            err <= 1'b0;
        end else begin
            acc <= acc_n;
            acc_cnt <= cnt_n;
            err <= err_n;
            if (accept) byte_cnt <= byte_cnt + 9'd1;
            if (ext) begin
                decomp_dout_1 <= 16'((PW'(acc[D-1:0]) * QW + HALF) >> D);
                decomp_dout_2 <= 16'((PW'(acc[2*D-1:D]) * QW + HALF) >> D);
                out_index <= pair_cnt;
                pair_cnt <= pair_cnt + 7'd1;
                readout_ok <= 1'b1;
            end else if (take) begin
                readout_ok <= 1'b0;
            end
        end
    end
endmodule
